// File: rtl/logic_gate_unit_if.sv
// Handshake bundle for logic_gate_unit: operand side (in_*), result side (out_*)
// and the delivered-result counter.
interface logic_gate_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_any;
    logic             out_all;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output in_valid, op, in1, in2, out_ready,
        input  in_ready, out_valid, out, out_any, out_all, txn_cnt
    );

    modport slave (
        input  in_valid, op, in1, in2, out_ready,
        output in_ready, out_valid, out, out_any, out_all, txn_cnt
    );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered, stallable eight-op bitwise gate stage with reduction flags and a result counter.
// Define LOGIC_GATE_UNIT_SKID_EN for a two-entry skid buffer with registered in_ready.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_gate_unit_if.slave   bus
);
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             any;
        logic             all;
    } ent_t;

    logic [WIDTH-1:0] res_c;
    ent_t             new_ent;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    ent_t             ent0_q, ent0_d;

    always_comb begin
        res_c = '0;
        case (bus.op)
            3'b000:  res_c = bus.in1 & bus.in2;
            3'b001:  res_c = bus.in1 | bus.in2;
            3'b010:  res_c = bus.in1 ^ bus.in2;
            3'b011:  res_c = ~(bus.in1 & bus.in2);
            3'b100:  res_c = ~(bus.in1 | bus.in2);
            3'b101:  res_c = ~(bus.in1 ^ bus.in2);
            3'b110:  res_c = bus.in1;
            default: res_c = ~bus.in1;
        endcase
        new_ent.res = res_c;
        new_ent.any = |res_c;
        new_ent.all = &res_c;
    end

`ifdef LOGIC_GATE_UNIT_SKID_EN
    // ent0 is always the oldest entry; ent1 only holds data at occupancy 2.
    logic [1:0] occ_q, occ_d;
    ent_t       ent1_q, ent1_d;
    logic       in_ready_q, in_ready_d;

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (occ_q != 2'd0) && bus.out_ready;

    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = new_ent;
                else               ent1_d = new_ent;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = new_ent;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent;
                end
            end
            default: ;
        endcase
        in_ready_d = (occ_d < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (occ_q != 2'd0);
`else
    logic vld_q, vld_d;

    // A delivering consumer frees the register in the same cycle.
    assign bus.in_ready = !vld_q || bus.out_ready;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = vld_q && bus.out_ready;

    always_comb begin
        ent0_d = push ? new_ent : ent0_q;
        vld_d  = push || (vld_q && !bus.out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ent0_q <= '0;
        end else begin
            vld_q  <= vld_d;
            ent0_q <= ent0_d;
        end
    end

    assign bus.out_valid = vld_q;
`endif

    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (pop) txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) txn_cnt_q <= '0;
        else        txn_cnt_q <= txn_cnt_d;
    end

    assign bus.out     = ent0_q.res;
    assign bus.out_any = ent0_q.any;
    assign bus.out_all = ent0_q.all;
    assign bus.txn_cnt = txn_cnt_q;
endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed and random checks of logic_gate_unit against an in-order expected-result queue.
module tb_logic_gate_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   acc;
    logic [15:0] exp_cnt;
    logic [7:0]  q[$];
    int   wrap_exp[5] = '{1, 2, 3, 0, 1};
    logic [7:0]  dir_exp[8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5, 8'h5A};

    logic_gate_unit_if #(.WIDTH(8), .CNT_W(16)) u_if ();
    logic_gate_unit_if #(.WIDTH(8), .CNT_W(2))  w_if ();

    logic_gate_unit #(.WIDTH(8), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
    logic_gate_unit #(.WIDTH(8), .CNT_W(2))  w_dut (.clk(clk), .rst_n(rst_n), .bus(w_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a;
            default: return ~a;
        endcase
    endfunction

    // Drive one cycle, check outputs against the model, then account for the handshakes at the next edge.
    task automatic step(input logic v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic ordy, input logic [7:0] er);
        logic exp_rdy;
        @(negedge clk);
        u_if.in_valid  = v;
        u_if.op        = o;
        u_if.in1       = a;
        u_if.in2       = b;
        u_if.out_ready = ordy;
        #1;
        chk("txn_cnt", 32'(u_if.txn_cnt), 32'(exp_cnt));
        chk("out_valid", 32'(u_if.out_valid), 32'(q.size() != 0));
`ifdef LOGIC_GATE_UNIT_SKID_EN
        exp_rdy = (q.size() < 2);
`else
        exp_rdy = (q.size() == 0) || ordy;
`endif
        chk("in_ready", 32'(u_if.in_ready), 32'(exp_rdy));
        if (u_if.out_valid && q.size() != 0) begin
            chk("out", 32'(u_if.out), 32'(q[0]));
            chk("out_any", 32'(u_if.out_any), 32'(|q[0]));
            chk("out_all", 32'(u_if.out_all), 32'(&q[0]));
            if (ordy) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
        end
        if (v && u_if.in_ready) begin
            q.push_back(er);
            acc++;
        end
    endtask

    initial begin
        logic [2:0] ro;
        logic [7:0] ra, rb;
        checks = 0; failures = 0; acc = 0; exp_cnt = '0;
        rst_n = 1'b0;
        u_if.in_valid = 0; u_if.op = 0; u_if.in1 = 0; u_if.in2 = 0; u_if.out_ready = 0;
        w_if.in_valid = 0; w_if.op = 0; w_if.in1 = 0; w_if.in2 = 0; w_if.out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(u_if.out_valid), 0);
        chk("rst_out", 32'(u_if.out), 0);
        chk("rst_any", 32'(u_if.out_any), 0);
        chk("rst_all", 32'(u_if.out_all), 0);
        chk("rst_cnt", 32'(u_if.txn_cnt), 0);
        chk("rst_in_ready", 32'(u_if.in_ready), 1);

        // All eight ops on A5/0F at full throughput
        for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 8'hA5, 8'h0F, 1'b1, dir_exp[k]);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        chk("cnt_after_ops", 32'(u_if.txn_cnt), 8);

        // Reduction flag corners
        step(1'b1, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00);
        step(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b1, 8'hFF);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);

        // Backpressure
        acc = 0;
        step(1'b1, 3'd1, 8'h11, 8'h22, 1'b0, 8'h33);
        step(1'b1, 3'd2, 8'h3C, 8'h0F, 1'b0, 8'h33);
        step(1'b1, 3'd7, 8'h81, 8'h00, 1'b0, 8'h7E);
`ifdef LOGIC_GATE_UNIT_SKID_EN
        chk("bp_accepted", 32'(acc), 2);
`else
        chk("bp_accepted", 32'(acc), 1);
`endif
        chk("bp_in_ready", 32'(u_if.in_ready), 0);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        chk("bp_drained", 32'(q.size()), 0);

        // Counter wrap on the CNT_W=2 instance
        @(negedge clk);
        w_if.in_valid = 1; w_if.out_ready = 1; w_if.op = 3'b110; w_if.in1 = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) w_if.in_valid = 0;
            if (i >= 1) chk("wrap_cnt", 32'(w_if.txn_cnt), 32'(wrap_exp[i-1]));
        end

        // Asynchronous reset with results pending
        step(1'b1, 3'd6, 8'hC3, 8'h00, 1'b0, 8'hC3);
        step(1'b1, 3'd6, 8'h96, 8'h00, 1'b0, 8'h96);
        @(posedge clk);
        #3;
        u_if.in_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(u_if.out_valid), 0);
        chk("mid_rst_cnt", 32'(u_if.txn_cnt), 0);
        chk("mid_rst_in_ready", 32'(u_if.in_ready), 1);
        q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);

        // Random stress
        for (int n = 0; n < 10000; n++) begin
            ro = 3'($urandom_range(7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            step(1'($urandom_range(1)), ro, ra, rb, 1'($urandom_range(1)), ref_op(ro, ra, rb));
        end
        for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        chk("rand_drained", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

- Parametrised, registered successor to the single two-input gates.
- Applies one of eight selectable bitwise operations to two `WIDTH`-bit operands under a valid/ready handshake.
- Registers the result together with reduction flags, and counts delivered results.
- Sits between operand producers and result consumers wherever a stallable, configurable gate stage is needed.

## Interface

Parameters:
- `WIDTH`, 8, operand/result width in bits (≥1)
- `CNT_W`, 16, width of delivered-result counter (≥1)

Ports:
- `clk`  input  1  clock, all state updates on rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `in_valid`  input  1  operands and `op` valid
- `in_ready`  output  1  unit accepts operands this cycle
- `op`  input  3  operation select, sampled with operands
- `in1`  input  WIDTH  operand 1
- `in2`  input  WIDTH  operand 2
- `out_valid`  output  1  result valid
- `out_ready`  input  1  consumer accepts result this cycle
- `out`  output  WIDTH  result
- `out_any`  output  1  OR-reduction of `out`
- `out_all`  output  1  AND-reduction of `out`
- `txn_cnt`  output  CNT_W  count of delivered results

## Operation

- Clock is `clk`. Reset `rst_n` is asynchronous and active-low.
- Input handshake: `in_valid && in_ready` at a rising edge accepts `op`, `in1`, `in2`.
- Output handshake: `out_valid && out_ready` at a rising edge delivers `out`, `out_any`, `out_all`.
- `op` encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 PASS (`out = in1`)
  - 111 NOT (`out = ~in1`)
  - For PASS and NOT, `in2` is ignored.
- Result storage:
  - Result and both flags are computed at acceptance and stored together.
  - They are held stable while `out_valid && !out_ready`.
- Ordering: results are delivered strictly in acceptance order, with none dropped or duplicated.
- Result counter:
  - `txn_cnt` increments by 1 on each output handshake.
  - It wraps from 2^CNT_W−1 to 0 and never saturates.
- Input rules:
  - `in_valid` may deassert without a handshake; no state change results.
  - Inputs are don't-care while `in_valid` = 0.
- Reset:
  - Asserting `rst_n` low at any time, including mid-transfer, immediately clears all stored results and the counter.
  - Pending results are discarded.
- Reset values:
  - `out_valid` = 0
  - `out` = 0
  - `out_any` = 0
  - `out_all` = 0
  - `txn_cnt` = 0
  - `in_ready` = 1

## Timing

- Latency: an operand accepted at edge N produces `out_valid` = 1 after edge N with the result, provided storage was empty.
- Throughput: one result per cycle when `out_ready` is held high.
- Without skid storage (see Configuration):
  - A single result register.
  - `in_ready = !out_valid || out_ready`, a combinational path from `out_ready`.
  - Simultaneous delivery and acceptance in one cycle replaces the register contents; `out_valid` stays 1.
- With skid storage:
  - Two-entry in-order buffer; `in_ready` is registered and equals (occupancy < 2).
  - Occupancy 0 with push: becomes 1.
  - Occupancy 1 with push and pop in the same cycle: stays 1, and the new result follows the delivered one.
  - Occupancy 2: `in_ready` = 0, so no push is possible; a pop makes it 1, and `in_ready` = 1 from the next cycle.
  - `out` always presents the oldest entry.
- First cycle after reset release: `in_ready` = 1 and `out_valid` = 0.

## Configuration

- Macro: `LOGIC_GATE_UNIT_SKID_EN`.
- Defined:
  - Two-entry skid buffer; `in_ready` is registered with no combinational dependency on `out_ready`.
  - Sustains full throughput across a one-cycle consumer stall.
- Undefined:
  - Single result register; `in_ready` depends combinationally on `out_ready`.
- All other behaviour, ports, latency and reset values are identical in both builds.

## Test plan

- Reset, then `out_ready` = 1 and WIDTH = 8: send `in1` = 8'hA5, `in2` = 8'h0F through ops 000–111.
  - Required `out`: 05, AF, AA, FA, 50, 55, A5, 5A in order.
  - `out_any` = 1 for all.
  - `out_all` = 0 for all.
  - `txn_cnt` = 8.
- Zero/all-ones flags:
  - AND of 8'h00, 8'hFF → `out` = 00, `out_any` = 0, `out_all` = 0.
  - OR of 8'hF0, 8'h0F → `out` = FF, `out_any` = 1, `out_all` = 1.
- Backpressure: hold `out_ready` = 0 while pushing 3 transactions.
  - Without skid: exactly 1 accepted.
  - With skid: exactly 2 accepted, then `in_ready` = 0.
  - Release `out_ready`: results emerge in order with stable values during the stall.
- Counter wrap: CNT_W = 2, deliver 5 results → `txn_cnt` sequence 1, 2, 3, 0, 1.
- Mid-transfer reset: 2 results pending with `out_ready` = 0, pulse `rst_n` low asynchronously between edges.
  - Required immediately: `out_valid` = 0, `txn_cnt` = 0, `in_ready` = 1.
  - No stale result appears afterwards.
- Random stress: random `in_valid`, `out_ready` and `op` over 10000 cycles, compared against a reference queue model.
  - Required: zero mismatches, no drops or duplicates.
  - Run in both macro builds.
